// File: rtl/ex.sv
// EX stage: ALU, branch target, destination select and the EX/MEM pipeline register,
// plus an iterative 32-cycle unsigned multiply/divide unit that owns HI/LO.
module ex #(
    parameter int MD_CYCLES = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_con_ex_aluop,
    input  logic        i_con_ex_alusrc,
    input  logic        i_con_ex_regdst,
    input  logic        i_con_mem_branch,
    input  logic        i_con_mem_memread,
    input  logic        i_con_mem_memwrite,
    input  logic        i_con_wb_memtoreg,
    input  logic        i_con_wb_regwrite,
    input  logic        i_con_flush,
    input  logic [31:0] i_data_PC4,
    input  logic [31:0] i_data_Rs,
    input  logic [31:0] i_data_Rt,
    input  logic [31:0] i_data_Imm,
    input  logic [4:0]  i_addr_Rt,
    input  logic [4:0]  i_addr_Rd,
    output logic        o_con_mem_branch,
    output logic        o_con_mem_memread,
    output logic        o_con_mem_memwrite,
    output logic        o_con_wb_memtoreg,
    output logic        o_con_wb_regwrite,
    output logic        o_con_Zero,
    output logic [31:0] o_data_BranchAddr,
    output logic [31:0] o_data_ALU_Rst,
    output logic [31:0] o_data_WriteData,
    output logic [4:0]  o_addr_MuxRst,
    output logic        o_stall
);

    localparam int CW = $clog2(MD_CYCLES);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_MULT = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_MFHI = 4'd10;
    localparam logic [3:0] OP_MFLO = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    md_state_t      state;
    logic [CW-1:0]  md_cnt;
    logic           md_is_div;
    logic [31:0]    md_op;      // multiplicand (mul) or divisor (div)
    logic [31:0]    md_hi;      // running product high half / partial remainder
    logic [31:0]    md_lo;      // multiplier bits / quotient being shifted in
    logic [31:0]    hi, lo;

    logic [31:0] alu_a, alu_b, alu_rst;
    logic [4:0]  dst_addr;
    logic        is_md, md_issue, bubble;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [31:0] step_hi, step_lo;

    assign alu_a    = i_data_Rs;
    assign alu_b    = i_con_ex_alusrc ? i_data_Imm : i_data_Rt;
    assign dst_addr = i_con_ex_regdst ? i_addr_Rd : i_addr_Rt;

    assign is_md    = (i_con_ex_aluop == OP_MULT) || (i_con_ex_aluop == OP_DIV);
    assign md_issue = (state == S_IDLE) && is_md && !i_con_flush;
    assign o_stall  = !i_rst && (md_issue || (state == S_BUSY && !i_con_flush));
    assign bubble   = o_stall || i_con_flush;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_rst = '0;
        unique case (i_con_ex_aluop)
            OP_AND:  alu_rst = alu_a & alu_b;
            OP_OR:   alu_rst = alu_a | alu_b;
            OP_ADD:  alu_rst = alu_a + alu_b;
            OP_SUB:  alu_rst = alu_a - alu_b;
            OP_SLT:  alu_rst = {31'd0, $signed(alu_a) < $signed(alu_b)};
            OP_NOR:  alu_rst = ~(alu_a | alu_b);
            OP_SLTU: alu_rst = {31'd0, alu_a < alu_b};
            OP_XOR:  alu_rst = alu_a ^ alu_b;
            OP_MFHI: alu_rst = hi;
            OP_MFLO: alu_rst = lo;
            default: alu_rst = '0;
        endcase
    end

    // One shift-add (mul) or restoring-subtract (div) iteration; a zero divisor
    // naturally yields an all-ones quotient and the dividend as remainder.
    always_comb begin
        mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_op} : 33'd0);
        div_shift = {md_hi, md_lo[31]};
        div_ge    = div_shift >= {1'b0, md_op};
        div_diff  = div_shift[31:0] - md_op;
        if (md_is_div) begin
            step_hi = div_ge ? div_diff : div_shift[31:0];
            step_lo = {md_lo[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], md_lo[31:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            md_cnt    <= '0;
            md_is_div <= 1'b0;
            md_op     <= '0;
            md_hi     <= '0;
            md_lo     <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (md_issue) begin
                    state     <= S_BUSY;
                    md_cnt    <= '0;
                    md_is_div <= (i_con_ex_aluop == OP_DIV);
                    md_op     <= (i_con_ex_aluop == OP_DIV) ? alu_b : alu_a;
                    md_lo     <= (i_con_ex_aluop == OP_DIV) ? alu_a : alu_b;
                    md_hi     <= '0;
                end
                S_BUSY: if (i_con_flush) begin
                    state <= S_IDLE;
                end else begin
                    md_hi  <= step_hi;
                    md_lo  <= step_lo;
                    md_cnt <= md_cnt + 1'b1;
                    if (md_cnt == CW'(MD_CYCLES - 1)) begin
                        state <= S_DONE;
                        hi    <= step_hi;
                        lo    <= step_lo;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || bubble) begin
            o_con_mem_branch   <= 1'b0;
            o_con_mem_memread  <= 1'b0;
            o_con_mem_memwrite <= 1'b0;
            o_con_wb_memtoreg  <= 1'b0;
            o_con_wb_regwrite  <= 1'b0;
            o_con_Zero         <= 1'b0;
            o_data_BranchAddr  <= '0;
            o_data_ALU_Rst     <= '0;
            o_data_WriteData   <= '0;
            o_addr_MuxRst      <= '0;
        end else begin
            o_con_mem_branch   <= i_con_mem_branch;
            o_con_mem_memread  <= i_con_mem_memread;
            o_con_mem_memwrite <= i_con_mem_memwrite;
            o_con_wb_memtoreg  <= i_con_wb_memtoreg;
            o_con_wb_regwrite  <= i_con_wb_regwrite;
            o_con_Zero         <= (alu_rst == 32'd0);
            o_data_BranchAddr  <= i_data_PC4 + {i_data_Imm[29:0], 2'b00};
            o_data_ALU_Rst     <= alu_rst;
            o_data_WriteData   <= i_data_Rt;
            o_addr_MuxRst      <= dst_addr;
        end
    end

endmodule

// File: tb/tb_ex.sv
// Directed bench for the EX stage: table-driven ALU vectors plus hand-written
// multiply/divide, flush and asynchronous-reset sequences.
module tb_ex;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [3:0]  aluop;
    logic        alusrc, regdst, flush;
    logic [4:0]  ctl_in;
    logic [31:0] pc4, rs, rt, imm;
    logic [4:0]  addr_rt, addr_rd;

    logic        o_br, o_mr, o_mw, o_m2r, o_rw, o_zero, o_stall;
    logic [31:0] o_baddr, o_alu, o_wdata;
    logic [4:0]  o_dst;
    logic [4:0]  ctl_out;

    int errors = 0;
    int checks = 0;

    assign ctl_out = {o_br, o_mr, o_mw, o_m2r, o_rw};

    always #5 i_clk = ~i_clk;

    ex dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_con_ex_aluop     (aluop),
        .i_con_ex_alusrc    (alusrc),
        .i_con_ex_regdst    (regdst),
        .i_con_mem_branch   (ctl_in[4]),
        .i_con_mem_memread  (ctl_in[3]),
        .i_con_mem_memwrite (ctl_in[2]),
        .i_con_wb_memtoreg  (ctl_in[1]),
        .i_con_wb_regwrite  (ctl_in[0]),
        .i_con_flush        (flush),
        .i_data_PC4         (pc4),
        .i_data_Rs          (rs),
        .i_data_Rt          (rt),
        .i_data_Imm         (imm),
        .i_addr_Rt          (addr_rt),
        .i_addr_Rd          (addr_rd),
        .o_con_mem_branch   (o_br),
        .o_con_mem_memread  (o_mr),
        .o_con_mem_memwrite (o_mw),
        .o_con_wb_memtoreg  (o_m2r),
        .o_con_wb_regwrite  (o_rw),
        .o_con_Zero         (o_zero),
        .o_data_BranchAddr  (o_baddr),
        .o_data_ALU_Rst     (o_alu),
        .o_data_WriteData   (o_wdata),
        .o_addr_MuxRst      (o_dst),
        .o_stall            (o_stall)
    );

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic        dsel;
        logic [31:0] rs, rt, imm, pc4;
        logic [4:0]  art, ard, ctl;
        logic [31:0] e_alu;
        logic        e_zero;
        logic [31:0] e_br;
        logic [4:0]  e_dst;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        aluop = op; alusrc = 1'b0; regdst = 1'b1; flush = 1'b0;
        ctl_in = 5'b00001; pc4 = '0; imm = '0;
        rs = a; rt = b; addr_rt = 5'd3; addr_rd = 5'd4;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {o_alu, o_baddr, o_wdata, o_dst, ctl_out, o_zero}, '0);
    endtask

    // Issue a MULTU/DIVU, count stalled cycles, verify bubbles and the drain in DONE.
    task automatic run_md(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int cycles = 0;
        int bad = 0;
        drive_op(op, a, b);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!o_stall) break;
            cycles++;
            step();
            if ({ctl_out, o_alu, o_zero} != '0) bad++;
        end
        check({name, " stall cycles"}, cycles, 33);
        check({name, " bubbles"}, bad, 0);
        step();
        check({name, " drain"}, {ctl_out, o_alu, o_dst, o_zero}, {5'b00001, 32'd0, 5'd4, 1'b1});
    endtask

    task automatic read_hilo(input string name, input logic [31:0] e_hi, input logic [31:0] e_lo);
        drive_op(4'd10, '0, '0);
        step();
        check({name, " MFHI"}, o_alu, e_hi);
        drive_op(4'd11, '0, '0);
        step();
        check({name, " MFLO"}, o_alu, e_lo);
    endtask

    vec_t vecs[13];

    initial begin
        i_rst = 1'b1;
        drive_op(4'd0, '0, '0);
        ctl_in = '0;
        #12;
        check_all_zero("power-on reset outputs");
        check("power-on reset stall", o_stall, 0);
        i_rst = 1'b0;

        //          op    src   dsel  rs            rt            imm           pc4           art   ard   ctl       e_alu         z     e_br          e_dst
        vecs[0]  = '{4'd2, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000100, 5'd3, 5'd5, 5'b00001, 32'h80000000, 1'b0, 32'h000000FC, 5'd5};
        vecs[1]  = '{4'd3, 1'b0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h00000200, 5'd3, 5'd5, 5'b00011, 32'h7FFFFFFE, 1'b0, 32'h00000200, 5'd5};
        vecs[2]  = '{4'd3, 1'b0, 1'b0, 32'h00000003, 32'h00000003, 32'h00000001, 32'h00000000, 5'd7, 5'd5, 5'b10000, 32'h00000000, 1'b1, 32'h00000004, 5'd7};
        vecs[3]  = '{4'd4, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 5'd3, 5'd8, 5'b00001, 32'h00000001, 1'b0, 32'h00000000, 5'd8};
        vecs[4]  = '{4'd6, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 5'd3, 5'd8, 5'b00001, 32'h00000000, 1'b1, 32'h00000000, 5'd8};
        vecs[5]  = '{4'd0, 1'b1, 1'b0, 32'hF0F000FF, 32'h12345678, 32'h00000F0F, 32'h00001000, 5'd9, 5'd2, 5'b01010, 32'h0000000F, 1'b0, 32'h00004C3C, 5'd9};
        vecs[6]  = '{4'd1, 1'b0, 1'b1, 32'hF0000000, 32'h0000000F, 32'h00000000, 32'h00000000, 5'd3, 5'd31, 5'b00101, 32'hF000000F, 1'b0, 32'h00000000, 5'd31};
        vecs[7]  = '{4'd5, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 5'd3, 5'd1, 5'b00001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 5'd1};
        vecs[8]  = '{4'd7, 1'b0, 1'b1, 32'hAAAA5555, 32'hFFFF0000, 32'h00000000, 32'h00000000, 5'd3, 5'd6, 5'b00001, 32'h55555555, 1'b0, 32'h00000000, 5'd6};
        vecs[9]  = '{4'd12, 1'b0, 1'b1, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 5'd3, 5'd6, 5'b11111, 32'h00000000, 1'b1, 32'h00000000, 5'd6};
        vecs[10] = '{4'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'hFFFFFFFC, 5'd3, 5'd10, 5'b00001, 32'h00000000, 1'b1, 32'h00000000, 5'd10};
        vecs[11] = '{4'd4, 1'b0, 1'b1, 32'h00000001, 32'h80000000, 32'h00000000, 32'h00000000, 5'd3, 5'd11, 5'b00001, 32'h00000000, 1'b1, 32'h00000000, 5'd11};
        vecs[12] = '{4'd6, 1'b0, 1'b1, 32'h00000001, 32'h80000000, 32'h00000000, 32'h00000000, 5'd3, 5'd11, 5'b00001, 32'h00000001, 1'b0, 32'h00000000, 5'd11};

        for (int i = 0; i < 13; i++) begin
            aluop = vecs[i].op; alusrc = vecs[i].src; regdst = vecs[i].dsel; flush = 1'b0;
            rs = vecs[i].rs; rt = vecs[i].rt; imm = vecs[i].imm; pc4 = vecs[i].pc4;
            addr_rt = vecs[i].art; addr_rd = vecs[i].ard; ctl_in = vecs[i].ctl;
            step();
            check($sformatf("vec%0d alu", i), o_alu, vecs[i].e_alu);
            check($sformatf("vec%0d zero", i), o_zero, vecs[i].e_zero);
            check($sformatf("vec%0d branch", i), o_baddr, vecs[i].e_br);
            check($sformatf("vec%0d dst", i), o_dst, vecs[i].e_dst);
            check($sformatf("vec%0d wdata", i), o_wdata, vecs[i].rt);
            check($sformatf("vec%0d ctl", i), ctl_out, vecs[i].ctl);
        end

        run_md("multu max", 4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
        read_hilo("multu max", 32'hFFFFFFFE, 32'h00000001);
        run_md("divu 100/7", 4'd9, 32'd100, 32'd7);
        read_hilo("divu 100/7", 32'd2, 32'd14);
        run_md("divu 5/0", 4'd9, 32'd5, 32'd0);
        read_hilo("divu 5/0", 32'd5, 32'hFFFFFFFF);

        // Preload HI=LO=0x1234 (0x1234*0x1236 / 0x1235), then flush a MULTU at BUSY cycle 10.
        run_md("divu preload", 4'd9, 32'h014B7EF8, 32'h00001235);
        read_hilo("divu preload", 32'h1234, 32'h1234);
        drive_op(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        repeat (10) step();
        flush = 1'b1;
        #1;
        check("flush busy stall drop", o_stall, 0);
        step();
        check_all_zero("flush busy bubble");
        drive_op(4'd10, '0, '0);
        #1;
        check("flush busy back to idle", o_stall, 0);
        step();
        check("flush busy MFHI kept", o_alu, 32'h1234);
        drive_op(4'd11, '0, '0);
        step();
        check("flush busy MFLO kept", o_alu, 32'h1234);

        drive_op(4'd2, 32'd1, 32'd1);
        ctl_in = 5'b11111; pc4 = 32'h40; imm = 32'h1; flush = 1'b1;
        step();
        check_all_zero("flush idle add");
        flush = 1'b0;

        // Asynchronous reset between edges with live EX/MEM contents and HI/LO=0x1234.
        drive_op(4'd2, 32'd2, 32'd3);
        step();
        check("pre-reset add", o_alu, 32'd5);
        #2 i_rst = 1'b1;
        #1;
        check_all_zero("async reset outputs");
        check("async reset stall", o_stall, 0);
        step();
        i_rst = 1'b0;
        read_hilo("after reset", 32'd0, 32'd0);

        // Reset while the unit is BUSY aborts it.
        drive_op(4'd8, 32'd3, 32'd3);
        step();
        step();
        step();
        #2 i_rst = 1'b1;
        #1;
        check("reset mid-busy stall", o_stall, 0);
        drive_op(4'd11, '0, '0);
        step();
        i_rst = 1'b0;
        #1;
        check("after busy reset idle", o_stall, 0);
        read_hilo("after busy reset", 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
